// File: rtl/uncache_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// uncache_mem_responder_pkg
// Shared types and constants for the uncached memory responder:
//   - uncache_state_t : read-path FSM states
//   - uncache_wbuf_t  : contents of the one-entry posted write buffer
//   - BUS_TYPE_WORD   : rd_type/wr_type encoding for a single 32-bit word
// No ports (package).
// ---------------------------------------------------------------------------
package uncache_mem_responder_pkg;

    localparam int UNC_ADDR_W = 32;
    localparam int UNC_DATA_W = 32;
    localparam int UNC_STRB_W = UNC_DATA_W / 8;

    localparam logic [2:0] BUS_TYPE_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        RD_DONE
    } uncache_state_t;

    typedef struct packed {
        logic                  valid;
        logic [UNC_ADDR_W-1:0] addr;
        logic [UNC_DATA_W-1:0] data;
        logic [UNC_STRB_W-1:0] strb;
    } uncache_wbuf_t;

    // The bus only ever sees word-aligned addresses.
    function automatic logic [UNC_ADDR_W-1:0] word_align(input logic [UNC_ADDR_W-1:0] a);
        return {a[UNC_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/uncache_mem_responder_wbuf.sv
// ---------------------------------------------------------------------------
// uncache_wbuf
// One-entry posted write buffer. A store is captured on fill and presented
// on the write bus until the bridge takes it (wr_req && wr_rdy).
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   fill                  capture fill_addr/fill_data/fill_strb this cycle
//   fill_addr/data/strb   store to capture (address already word-aligned)
//   wr_rdy                bridge accepts the buffered beat
//   wr_req                buffered beat valid
//   wr_addr/data/wstrb    buffered beat contents
//   empty                 no beat held (reads may start)
//   can_fill              buffer empty or draining this cycle
// ---------------------------------------------------------------------------
module uncache_wbuf
    import uncache_mem_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fill,
    input  logic [UNC_ADDR_W-1:0] fill_addr,
    input  logic [UNC_DATA_W-1:0] fill_data,
    input  logic [UNC_STRB_W-1:0] fill_strb,
    input  logic                  wr_rdy,
    output logic                  wr_req,
    output logic [UNC_ADDR_W-1:0] wr_addr,
    output logic [UNC_DATA_W-1:0] wr_data,
    output logic [UNC_STRB_W-1:0] wr_wstrb,
    output logic                  empty,
    output logic                  can_fill
);

    uncache_wbuf_t buf_reg;
    logic          drain;

    assign drain    = buf_reg.valid & wr_rdy;
    // A beat leaving this cycle frees the slot for a same-cycle refill.
    assign can_fill = ~buf_reg.valid | wr_rdy;
    assign empty    = ~buf_reg.valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_reg <= '0;
        end else if (fill) begin
            // Refill wins over drain so back-to-back stores keep the slot valid.
            buf_reg.valid <= 1'b1;
            buf_reg.addr  <= fill_addr;
            buf_reg.data  <= fill_data;
            buf_reg.strb  <= fill_strb;
        end else if (drain) begin
            buf_reg.valid <= 1'b0;
        end
    end

    assign wr_req   = buf_reg.valid;
    assign wr_addr  = buf_reg.addr;
    assign wr_data  = buf_reg.data;
    assign wr_wstrb = buf_reg.strb;

endmodule

// File: rtl/uncache_mem_responder.sv
// ---------------------------------------------------------------------------
// uncache_mem_responder
// Responder for uncached single-word loads/stores from EX. Loads become one
// read beat on the rd bus; stores are posted into a one-entry write buffer
// and acknowledged the next cycle. Loads wait for the buffer to drain, so
// bus order matches program order.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   uncache_en, op, virtual_addr,
//   wdata, wstrb                    request from EX (op: 0=load, 1=store)
//   addr_ok                         request accepted this cycle
//   data_ok, rdata                  completion pulse / load data
//   busy                            request in flight
//   rd_req, rd_type, rd_addr, rd_rdy              read request channel
//   ret_valid, ret_last, ret_data                 read return channel
//   wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
//   wr_rdy                                        posted write channel
// ---------------------------------------------------------------------------
module uncache_mem_responder
    import uncache_mem_responder_pkg::*;
#(
    // Buffer storage is sized by the package; keep these at their defaults.
    parameter int ADDR_WIDTH = UNC_ADDR_W,
    parameter int DATA_WIDTH = UNC_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    uncache_en,
    input  logic                    op,
    input  logic [ADDR_WIDTH-1:0]   virtual_addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    busy,
    output logic                    rd_req,
    output logic [2:0]              rd_type,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic                    rd_rdy,
    input  logic                    ret_valid,
    input  logic                    ret_last,
    input  logic [DATA_WIDTH-1:0]   ret_data,
    output logic                    wr_req,
    output logic [2:0]              wr_type,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [DATA_WIDTH/8-1:0] wr_wstrb,
    output logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    wr_rdy
);

    uncache_state_t          state_reg;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg;
    logic [DATA_WIDTH-1:0]   rdata_reg;
    logic                    data_ok_reg;

    logic                    buf_empty;
    logic                    buf_can_fill;
    logic                    is_load;
    logic                    is_store;
    logic                    load_go;
    logic                    store_go;
    logic                    ret_done;
    logic [ADDR_WIDTH-1:0]   aligned_addr;
    logic                    unused_addr_bits;

    assign is_load  = uncache_en & ~op;
    assign is_store = uncache_en & op;

    // Loads only start with an empty buffer; stores may refill a draining one.
    assign load_go  = (state_reg == IDLE) & is_load  & buf_empty;
    assign store_go = (state_reg == IDLE) & is_store & buf_can_fill;
    assign ret_done = (state_reg == RD_WAIT) & ret_valid & ret_last;

    assign aligned_addr     = word_align(virtual_addr);
    assign unused_addr_bits = ^virtual_addr[1:0];

    // addr_ok is combinational; keep it low while reset is held.
    assign addr_ok = (load_go | store_go) & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            rd_addr_reg <= '0;
            rdata_reg   <= '0;
            data_ok_reg <= 1'b0;
        end else begin
            // A posted store acks next cycle; a load acks in RD_DONE.
            // Both cannot occur together: stores are only taken in IDLE.
            data_ok_reg <= store_go | ret_done;
            case (state_reg)
                IDLE: begin
                    if (load_go) begin
                        rd_addr_reg <= aligned_addr;
                        state_reg   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (rd_rdy) begin
                        state_reg <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Non-last beats are ignored; only the last one is kept.
                    if (ret_done) begin
                        rdata_reg <= ret_data;
                        state_reg <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    uncache_wbuf u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .fill      (store_go),
        .fill_addr (aligned_addr),
        .fill_data (wdata),
        .fill_strb (wstrb),
        .wr_rdy    (wr_rdy),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_wstrb  (wr_wstrb),
        .empty     (buf_empty),
        .can_fill  (buf_can_fill)
    );

    assign rd_req  = (state_reg == RD_REQ);
    assign rd_addr = rd_addr_reg;
    assign rd_type = BUS_TYPE_WORD;
    assign wr_type = BUS_TYPE_WORD;
    assign rdata   = rdata_reg;
    assign data_ok = data_ok_reg;
    assign busy    = (state_reg != IDLE) | (~buf_empty & is_load) | data_ok_reg;

endmodule

// File: tb/tb_uncache_mem_responder.sv
module tb_uncache_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        uncache_en, op;
    logic [31:0] virtual_addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok, busy;
    logic [31:0] rdata;
    logic        rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]  rd_type, wr_type;
    logic [31:0] rd_addr, ret_data;
    logic        wr_req, wr_rdy;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_wstrb;

    uncache_mem_responder dut (
        .clk(clk), .rst(rst), .uncache_en(uncache_en), .op(op),
        .virtual_addr(virtual_addr), .wdata(wdata), .wstrb(wstrb),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .busy(busy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    // Expectations pushed by the driver on acceptance, popped by the monitor.
    wbeat_t      wq[$];
    logic [31:0] rq[$];
    bit          resp_q[$];     // 1 = store ack, 0 = load data

    // Bus model controls
    int          wr_hold   = 0;
    bit          wr_block  = 0;
    bit          ret_hold  = 0;
    bit          use_fixed = 0;
    logic [31:0] fixed_data = 32'h0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle, act, exp);
        end
    endfunction

    // ---------------- bus bridge model ----------------
    initial begin : bus
        bit reading;
        int delay;
        int beats;
        reading = 0; delay = 0; beats = 0;
        rd_rdy = 0; wr_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                reading = 0;
            end else begin
                if (reading && ret_valid && ret_last) reading = 0;
                if (rd_req && rd_rdy) begin
                    reading = 1;
                    delay   = $urandom_range(0, 3);
                    beats   = $urandom_range(1, 3);
                end
            end
            @(posedge clk); #1;
            rd_rdy = ($urandom_range(0, 2) != 0);
            if (wr_block) wr_rdy = 1'b0;
            else if (wr_hold > 0) begin wr_rdy = 1'b0; wr_hold--; end
            else wr_rdy = ($urandom_range(0, 3) != 0);
            ret_valid = 0; ret_last = 0; ret_data = $urandom;
            if (reading) begin
                if (!ret_hold) begin
                    if (delay > 0) delay--;
                    else begin
                        ret_valid = 1;
                        beats--;
                        ret_last = (beats == 0);
                        if (ret_last && use_fixed) ret_data = fixed_data;
                    end
                end
            end else if ($urandom_range(0, 5) == 0) begin
                // stray return beats must be ignored
                ret_valid = 1;
                ret_last  = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int          ld_phase;   // 0 none, 1 await rd handshake, 2 await return, 3 await ack
        int          wpend;
        int          store_dok;
        int          load_dok;
        logic [31:0] exp_rdata;
        bit          dok_exp, exp_aok, exp_busy, kind;
        wbeat_t      wb;
        logic [31:0] ra;
        ld_phase = 0; wpend = 0; store_dok = -1; load_dok = -1; exp_rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ld_phase = 0; wpend = 0; store_dok = -1; load_dok = -1;
                wq.delete(); rq.delete(); resp_q.delete();
                continue;
            end
            dok_exp  = (cycle == store_dok) || (cycle == load_dok);
            exp_aok  = uncache_en && (ld_phase == 0) && (op ? (wpend == 0 || wr_rdy) : (wpend == 0));
            exp_busy = (ld_phase != 0) || (wpend != 0 && uncache_en && !op) || dok_exp;
            chk("data_ok", data_ok, dok_exp);
            chk("addr_ok", addr_ok, exp_aok);
            chk("busy", busy, exp_busy);
            chk("rd_req", rd_req, ld_phase == 1);
            chk("wr_req", wr_req, wpend != 0);
            chk("rd_wr_excl", rd_req & wr_req, 0);

            if (data_ok) begin
                if (resp_q.size() == 0) chk("resp_extra", 1, 0);
                else begin
                    kind = resp_q.pop_front();
                    chk("resp_kind", kind, cycle == store_dok);
                    if (!kind) chk("rdata", rdata, exp_rdata);
                    $display("resp cycle=%0d %s rdata=%h", cycle, kind ? "store" : "load", rdata);
                end
            end
            if (cycle == load_dok) ld_phase = 0;

            if (ld_phase == 2 && ret_valid && ret_last) begin
                exp_rdata = ret_data;
                load_dok  = cycle + 1;
                ld_phase  = 3;
            end
            if (rd_req && rd_rdy) begin
                if (rq.size() == 0) chk("rd_extra", 1, 0);
                else begin
                    ra = rq.pop_front();
                    chk("rd_addr", rd_addr, ra);
                    chk("rd_type", rd_type, 3'b010);
                end
                if (ld_phase == 1) ld_phase = 2;
            end
            if (wr_req && wr_rdy) begin
                if (wq.size() == 0) chk("wr_extra", 1, 0);
                else begin
                    wb = wq.pop_front();
                    chk("wr_addr", wr_addr, wb.addr);
                    chk("wr_data", wr_data, wb.data);
                    chk("wr_wstrb", wr_wstrb, wb.strb);
                    chk("wr_type", wr_type, 3'b010);
                    $display("wbeat cycle=%0d addr=%h data=%h strb=%h", cycle, wr_addr, wr_data, wr_wstrb);
                end
                if (wpend > 0) wpend--;
            end
            if (uncache_en && addr_ok) begin
                if (op) begin wpend++; store_dok = cycle + 1; end
                else ld_phase = 1;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_req(input bit st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        bit ok;
        uncache_en = 1; op = st; virtual_addr = a; wdata = d; wstrb = st ? s : 4'hF;
        ok = 0; n = 0;
        while (!ok && n < 300) begin
            @(negedge clk);
            if (addr_ok && !rst) ok = 1;
            else n++;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL accept_timeout cycle=%0d got=no addr_ok expected=addr_ok", cycle);
        end else begin
            resp_q.push_back(st);
            if (st) wq.push_back('{addr: {a[31:2], 2'b00}, data: d, strb: s});
            else    rq.push_back({a[31:2], 2'b00});
        end
        @(posedge clk); #1;
        uncache_en = 0; op = 1'($urandom_range(0, 1)); virtual_addr = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || wq.size() != 0 || busy) && n < 500) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_resp_q", resp_q.size(), 0);
        chk("drain_wq", wq.size(), 0);
    endtask

    initial begin : main
        int n;
        uncache_en = 0; op = 0; virtual_addr = 0; wdata = 0; wstrb = 0;
        #1 rst = 1;
        #1;
        chk("rst_addr_ok", addr_ok, 0);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd_req", rd_req, 0);
        chk("rst_wr_req", wr_req, 0);
        chk("rst_rdata", rdata, 0);
        repeat (3) @(posedge clk);
        #3 rst = 0;
        @(posedge clk); #1;

        // directed: load with fixed return data, held store, load behind it, back-to-back stores
        use_fixed = 1; fixed_data = 32'hDEADBEEF;
        do_req(0, 32'h1FAF_F004, 32'h0, 4'hF);
        wait_drain();
        use_fixed = 0;
        wr_hold = 6;
        do_req(1, 32'h1FAF_F002, 32'h00AB_00AB, 4'b0100);
        do_req(0, 32'h1FAF_F010, 32'h0, 4'hF);
        do_req(1, 32'h1FAF_F020, 32'h1111_2222, 4'b0011);
        do_req(1, 32'h1FAF_F024, 32'h3333_4444, 4'b1100);
        wr_hold = 4;
        do_req(1, 32'h1FAF_F028, 32'h5555_6666, 4'b1111);
        do_req(1, 32'h1FAF_F02C, 32'h7777_8888, 4'b0001);
        wait_drain();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if ($urandom_range(0, 15) == 0) wr_hold = $urandom_range(1, 6);
            do_req(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)));
        end
        wait_drain();

        // reset while a load waits for its return
        ret_hold = 1;
        do_req(0, 32'h2000_0008, 32'h0, 4'hF);
        n = 0;
        while (!(rd_req && rd_rdy) && n < 100) begin @(negedge clk); n++; end
        chk("rd_handshake_seen", rd_req && rd_rdy, 1);
        @(posedge clk); #2;
        chk("pre_rst_busy", busy, 1);
        rst = 1;
        #1;
        chk("arst_rd_req", rd_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_data_ok", data_ok, 0);
        chk("arst_addr_ok", addr_ok, 0);
        chk("arst_rdata", rdata, 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 0; ret_hold = 0;

        // reset while a store sits in the buffer and its ack is due
        @(posedge clk); #1;
        wr_block = 1;
        do_req(1, 32'h3000_0004, 32'hCAFE_F00D, 4'b1010);
        #1;
        chk("pre_rst_wr_req", wr_req, 1);
        chk("pre_rst_data_ok", data_ok, 1);
        rst = 1;
        #1;
        chk("arst_wr_req", wr_req, 0);
        chk("arst_data_ok2", data_ok, 0);
        chk("arst_busy2", busy, 0);
        @(posedge clk); @(posedge clk); #3;
        rst = 0; wr_block = 0;
        @(posedge clk); #1;

        // clean restart after reset
        do_req(0, 32'h4000_0010, 32'h0, 4'hF);
        do_req(1, 32'h4000_0014, 32'h0102_0304, 4'b1111);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
